// File: rtl/chan_bin_pkg.sv
// Shared constants for the channel-to-bin selection table controller.
// Opcodes, FSM states and register field positions live here.
package chan_bin_pkg;

    localparam int N_CHAN_DEF = 256;
    localparam int CHAN_W_DEF = 8;
    localparam int BIN_W_DEF  = 9;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_COMMIT  = 2'b01,
        OP_CLR_ERR = 2'b10,
        OP_COPY    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY_RD,
        S_COPY_WR,
        S_WAIT_SWAP
    } state_e;

    localparam int CFG_TOG_BIT  = 31;
    localparam int CFG_OP_LSB   = 29;
    localparam int CFG_CHAN_LSB = 16;
    localparam int CFG_BIN_LSB  = 0;

    localparam int ST_ACTIVE_BIT = 31;
    localparam int ST_PEND_BIT   = 30;
    localparam int ST_BUSY_BIT   = 29;
    localparam int ST_ERR_BIT    = 28;
    localparam int ST_CNT_W      = 16;

endpackage

// File: rtl/chan_bin_dpram.sv
// Simple dual-port table RAM: port A read-only, port B read/write.
// Both read ports register their data (1-cycle latency).
module chan_bin_dpram #(
    parameter int AW = 9,
    parameter int DW = 9
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] a_addr_i,
    output logic [DW-1:0] a_rdata_o,
    input  logic [AW-1:0] b_addr_i,
    input  logic          b_we_i,
    input  logic [DW-1:0] b_wdata_i,
    output logic [DW-1:0] b_rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
    end

    // Output registers reset so the datapath sees 0 before any lookup.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rdata_o <= '0;
            b_rdata_o <= '0;
        end else begin
            a_rdata_o <= mem_q[a_addr_i];
            b_rdata_o <= mem_q[b_addr_i];
        end
    end

endmodule

// File: rtl/chan_bin_table_ctrl.sv
// Double-buffered channel-to-bin table: toggle-driven command decode,
// shadow-bank writes/copies and frame-aligned bank swap.
import chan_bin_pkg::*;

module chan_bin_table_ctrl #(
    parameter int N_CHAN = N_CHAN_DEF,
    parameter int CHAN_W = CHAN_W_DEF,
    parameter int BIN_W  = BIN_W_DEF
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       cfg_word,
    input  logic              frame_sync,
    input  logic [CHAN_W-1:0] rd_chan,
    output logic [BIN_W-1:0]  rd_bin,
    output logic [31:0]       status_word,
    output logic              active_bank
);

    logic [31:0]         cfg_q;
    logic                tog_q;
    logic                started_q;
    state_e              state_q, state_d;
    logic [CHAN_W-1:0]   addr_q, addr_d;
    logic                active_q, active_d;
    logic                err_q, err_d;
    logic [ST_CNT_W-1:0] cnt_q, cnt_d;

    logic              cmd;
    op_e               op;
    logic [CHAN_W-1:0] chan;
    logic [BIN_W-1:0]  bin;
    logic              busy;
    logic              pend;
    logic              rd_bank;

    logic              b_we;
    logic [CHAN_W:0]   b_addr;
    logic [BIN_W-1:0]  b_wdata;
    logic [BIN_W-1:0]  b_rdata;

    logic unused_cfg;
    assign unused_cfg = ^{cfg_q[28:25], cfg_q[24:CFG_CHAN_LSB+CHAN_W],
                          cfg_q[15:BIN_W]};

    // The first cycle after reset only samples the toggle, never fires.
    assign cmd  = started_q & (cfg_q[CFG_TOG_BIT] ^ tog_q);
    assign op   = op_e'(cfg_q[CFG_OP_LSB +: 2]);
    assign chan = cfg_q[CFG_CHAN_LSB +: CHAN_W];
    assign bin  = cfg_q[CFG_BIN_LSB +: BIN_W];

    assign busy    = (state_q == S_COPY_RD) || (state_q == S_COPY_WR);
    assign pend    = (state_q == S_WAIT_SWAP);
    assign rd_bank = active_q ^ (pend & frame_sync);

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            cfg_q     <= '0;
            tog_q     <= 1'b0;
            started_q <= 1'b0;
            state_q   <= S_IDLE;
            addr_q    <= '0;
            active_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            cfg_q     <= cfg_word;
            tog_q     <= started_q ? cfg_q[CFG_TOG_BIT] : cfg_word[CFG_TOG_BIT];
            started_q <= 1'b1;
            state_q   <= state_d;
            addr_q    <= addr_d;
            active_q  <= active_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        active_d = active_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        b_we     = 1'b0;
        b_addr   = {~active_q, chan};
        b_wdata  = bin;

        if (cmd && op == OP_CLR_ERR) begin
            err_d = 1'b0;
        end else if (cmd && state_q != S_IDLE) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd) begin
                    unique case (op)
                        OP_WRITE: begin
                            b_we  = 1'b1;
                            cnt_d = cnt_q + 1'b1;
                        end
                        OP_COMMIT: state_d = S_WAIT_SWAP;
                        OP_COPY: begin
                            state_d = S_COPY_RD;
                            addr_d  = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_COPY_RD: begin
                b_addr  = {active_q, addr_q};
                state_d = S_COPY_WR;
            end
            S_COPY_WR: begin
                b_addr  = {~active_q, addr_q};
                b_we    = 1'b1;
                b_wdata = b_rdata;
                if (addr_q == CHAN_W'(N_CHAN - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_COPY_RD;
                end
            end
            S_WAIT_SWAP: begin
                if (frame_sync) begin
                    active_d = ~active_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    chan_bin_dpram #(
        .AW(CHAN_W + 1),
        .DW(BIN_W)
    ) u_ram (
        .clk_i    (user_clk),
        .rst_ni   (user_rst_n),
        .a_addr_i ({rd_bank, rd_chan}),
        .a_rdata_o(rd_bin),
        .b_addr_i (b_addr),
        .b_we_i   (b_we),
        .b_wdata_i(b_wdata),
        .b_rdata_o(b_rdata)
    );

    assign active_bank = active_q;
    assign status_word = {active_q, pend, busy, err_q, 12'b0, cnt_q};

endmodule

// File: tb/tb_chan_bin_table_ctrl.sv
// Randomized bench for chan_bin_table_ctrl against a bank-array model.
// Commands are issued through the toggle protocol, one at a time.
module tb_chan_bin_table_ctrl;

    localparam int NC = 256;
    localparam int M_IDLE = 0;
    localparam int M_COPY = 1;
    localparam int M_PEND = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_word;
    logic        fs;
    logic [7:0]  rd_chan;
    logic [8:0]  rd_bin;
    logic [31:0] st;
    logic        act;

    always #5 clk = ~clk;

    chan_bin_table_ctrl dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .cfg_word   (cfg_word),
        .frame_sync (fs),
        .rd_chan    (rd_chan),
        .rd_bin     (rd_bin),
        .status_word(st),
        .active_bank(act)
    );

    int  n_vec = 0;
    int  n_err = 0;
    int  mem [2][NC];
    bit  vld [2][NC];
    bit  m_act;
    bit  m_err;
    int  m_cnt;
    int  m_mode;
    bit  tog;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = '0;
        s[31]    = m_act;
        s[30]    = (m_mode == M_PEND);
        s[29]    = (m_mode == M_COPY);
        s[28]    = m_err;
        s[15:0]  = m_cnt[15:0];
        return s;
    endfunction

    task automatic model_reset();
        m_act  = 1'b0;
        m_err  = 1'b0;
        m_cnt  = 0;
        m_mode = M_IDLE;
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < NC; k++) vld[b][k] = 1'b0;
    endtask

    task automatic send(string tag, logic [1:0] op, int c, int b, bit f);
        tog             = ~tog;
        cfg_word        = $urandom;
        cfg_word[31]    = tog;
        cfg_word[30:29] = op;
        cfg_word[23:16] = c[7:0];
        cfg_word[8:0]   = b[8:0];
        tick();
        fs = f;
        tick();
        fs = 1'b0;
        case (op)
            2'b00: begin
                if (m_mode == M_IDLE) begin
                    mem[!m_act][c] = b & 511;
                    vld[!m_act][c] = 1'b1;
                    m_cnt++;
                end else m_err = 1'b1;
            end
            2'b01: begin
                if (m_mode == M_IDLE) m_mode = M_PEND;
                else m_err = 1'b1;
            end
            2'b10: m_err = 1'b0;
            default: begin
                if (m_mode == M_IDLE) begin
                    m_mode = M_COPY;
                    for (int k = 0; k < NC; k++) vld[!m_act][k] = 1'b0;
                end else m_err = 1'b1;
            end
        endcase
        chk(tag, st, exp_status());
    endtask

    task automatic pulse(string tag, int c);
        rd_chan = c[7:0];
        fs      = 1'b1;
        tick();
        fs = 1'b0;
        if (m_mode == M_PEND) begin
            m_act  = ~m_act;
            m_mode = M_IDLE;
        end
        chk({tag, "_act"}, {31'b0, act}, {31'b0, m_act});
        chk({tag, "_st"}, st, exp_status());
        if (vld[m_act][c]) chk({tag, "_rd"}, {23'b0, rd_bin}, mem[m_act][c]);
    endtask

    task automatic lookup(int c);
        rd_chan = c[7:0];
        tick();
        if (vld[m_act][c]) chk("lookup", {23'b0, rd_bin}, mem[m_act][c]);
    endtask

    task automatic wait_copy(output int n);
        n = 0;
        while (st[29] && n < 2000) begin
            tick();
            n++;
        end
        for (int k = 0; k < NC; k++) begin
            mem[!m_act][k] = mem[m_act][k];
            vld[!m_act][k] = vld[m_act][k];
        end
        m_mode = M_IDLE;
    endtask

    initial begin
        int n;
        cfg_word = 32'h8000_0000;
        tog      = 1'b1;
        fs       = 1'b0;
        rd_chan  = '0;
        rst_n    = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_status", st, 32'h0);
        chk("rst_act", {31'b0, act}, 32'h0);
        chk("rst_rdbin", {23'b0, rd_bin}, 32'h0);

        rst_n = 1'b1;
        repeat (4) tick();
        chk("no_spurious", st, exp_status());

        send("wr5", 2'b00, 5, 300, 1'b0);
        send("commit1", 2'b01, 0, 0, 1'b0);
        pulse("swap1", 5);

        repeat (40) send("rnd_wr", 2'b00, $urandom_range(0, NC - 1),
                         $urandom_range(0, 511), 1'b0);
        send("commit2", 2'b01, 0, 0, 1'b0);
        pulse("swap2", $urandom_range(0, NC - 1));
        repeat (40) lookup($urandom_range(0, NC - 1));

        send("commit_fs", 2'b01, 0, 0, 1'b1);
        chk("commit_fs_act", {31'b0, act}, {31'b0, m_act});
        repeat (3) tick();
        pulse("swap_late", 5);

        for (int k = 0; k < NC; k++) send("fill", 2'b00, k, k + 100, 1'b0);
        send("commit3", 2'b01, 0, 0, 1'b0);
        pulse("swap3", 0);
        send("copy", 2'b11, 0, 0, 1'b0);
        wait_copy(n);
        chk("copy_len", n, 512);
        chk("copy_done_st", st, exp_status());
        send("commit4", 2'b01, 0, 0, 1'b0);
        pulse("swap4", 1);
        for (int k = 0; k < NC; k++) lookup(k);

        send("copy2", 2'b11, 0, 0, 1'b0);
        send("wr_in_copy", 2'b00, 9, 1, 1'b0);
        wait_copy(n);
        chk("copy2_len", n, 510);
        chk("copy2_st", st, exp_status());
        send("commit5", 2'b01, 0, 0, 1'b0);
        send("wr_in_wait", 2'b00, 3, 3, 1'b0);
        send("clr_err", 2'b10, 0, 0, 1'b0);
        pulse("swap5", 9);
        repeat (20) lookup($urandom_range(0, NC - 1));

        send("copy3", 2'b11, 0, 0, 1'b0);
        repeat (200) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_st", st, 32'h0);
        chk("midrst_act", {31'b0, act}, 32'h0);
        chk("midrst_rdbin", {23'b0, rd_bin}, 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_st", st, exp_status());
        send("post_wr", 2'b00, 7, 77, 1'b0);
        send("post_commit", 2'b01, 0, 0, 1'b0);
        pulse("post_swap", 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
